// File: rtl/keyevent_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : keyevent_decoder_pkg
// Brief   : Shared PS/2 set-2 byte codes, event layout and decoder states
// Revision: 1.0 - initial release
// ============================================================================
package keyevent_decoder_pkg;

  // Prefix and control bytes seen in the set-2 stream
  localparam logic [7:0] c_byte_f0 = 8'hF0;  // break prefix
  localparam logic [7:0] c_byte_e0 = 8'hE0;  // extended prefix
  localparam logic [7:0] c_byte_e1 = 8'hE1;  // Pause prefix
  localparam logic [7:0] c_byte_fa = 8'hFA;  // ACK
  localparam logic [7:0] c_byte_aa = 8'hAA;  // BAT passed
  localparam logic [7:0] c_byte_ee = 8'hEE;  // echo
  localparam logic [7:0] c_byte_fe = 8'hFE;  // resend

  // Pause sequence: E1 followed by this many bytes that are swallowed
  localparam logic [2:0] c_pause_len = 3'd7;

  // Event word: {ext, brk, code[7:0]}
  localparam int c_evt_w       = 10;
  localparam int c_evt_ext_bit = 9;
  localparam int c_evt_brk_bit = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXT    = 3'd1,
    ST_BRK    = 3'd2,
    ST_EXTBRK = 3'd3,
    ST_PAUSE  = 3'd4
  } dec_state_t;

  // Device status / filler bytes that never produce a key event
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == c_byte_fa) || (b == c_byte_aa) || (b == c_byte_ee) ||
           (b == c_byte_fe) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage
`default_nettype wire

// File: rtl/keyevent_decoder_if.sv
`default_nettype none
// ============================================================================
// Module  : keyevent_decoder_if
// Brief   : Byte-input / event-output bundle of the key event decoder
// Revision: 1.0 - initial release
// ============================================================================
interface keyevent_decoder_if #(
  parameter int DEPTH = 8
);
  import keyevent_decoder_pkg::*;

  logic                   i_byte_en;
  logic [7:0]             i_byte;
  logic                   o_valid;
  logic                   i_ready;
  logic [c_evt_w-1:0]     o_event;
  logic [7:0]             o_scancode;
  logic                   o_overflow;
  logic [$clog2(DEPTH):0] o_count;

  // Decoder side
  modport slave (
    input  i_byte_en, i_byte, i_ready,
    output o_valid, o_event, o_scancode, o_overflow, o_count
  );

  // Receiver / consumer side
  modport master (
    output i_byte_en, i_byte, i_ready,
    input  o_valid, o_event, o_scancode, o_overflow, o_count
  );

endinterface
`default_nettype wire

// File: rtl/keyevent_decoder_sfifo.sv
`default_nettype none
// ============================================================================
// Module  : keyevent_decoder_sfifo
// Brief   : Synchronous FIFO, head word read combinationally, exact count
// Revision: 1.0 - initial release
// ============================================================================
module keyevent_decoder_sfifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8
) (
  input  wire logic                   clk,
  input  wire logic                   i_arst_n,
  input  wire logic                   i_sclr,
  input  wire logic                   i_push,
  input  wire logic [W-1:0]           i_din,
  input  wire logic                   i_pop,
  output logic      [W-1:0]           o_dout,
  output logic                        o_empty,
  output logic                        o_full,
  output logic      [$clog2(DEPTH):0] o_count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  logic [W-1:0]    r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_cw-1:0] r_count;
  logic            w_wr;
  logic            w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_cw'(DEPTH));
  assign o_count = r_count;
  // Head is forced to zero when empty so stale storage never shows
  assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

  // A push into a full FIFO still lands when the head leaves on the same edge
  assign w_wr = i_push & (~o_full | i_pop);
  assign w_rd = i_pop & ~o_empty;

  // Pointer and occupancy bookkeeping; pointers wrap on power-of-2 depth
  always_ff @(posedge clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_sclr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset since the head is gated by empty
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_din;
  end

endmodule
`default_nettype wire

// File: rtl/keyevent_decoder.sv
`default_nettype none
// ============================================================================
// Module  : keyevent_decoder
// Brief   : PS/2 set-2 byte stream to tagged key events (E0/F0/E1 prefixes),
//           queued in an event FIFO; also tracks the last make code
// Revision: 1.0 - initial release
// ============================================================================
module keyevent_decoder
  import keyevent_decoder_pkg::*;
#(
  parameter int         DEPTH      = 8,
  parameter bit         BREAK_EN   = 1'b1,
  parameter logic [7:0] PAUSE_CODE = 8'hE1
) (
  input  wire logic        clk,
  input  wire logic        i_arst_n,
  input  wire logic        i_sclr,
  keyevent_decoder_if.slave bus
);

  dec_state_t             r_state;
  dec_state_t             w_state_nxt;
  logic [2:0]             r_cnt;
  logic [2:0]             w_cnt_nxt;
  logic                   w_emit;
  logic                   w_ext;
  logic                   w_brk;
  logic [7:0]             w_code;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_empty;
  logic                   w_full;
  logic [7:0]             r_scancode;
  logic                   r_overflow;
  logic [c_evt_w-1:0]     w_event_in;
  logic [$clog2(DEPTH):0] w_count;

  // Decoder state and Pause skip counter
  always_ff @(posedge clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (i_sclr) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Prefix resolution; only advances on strobed bytes
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_emit      = 1'b0;
    w_ext       = 1'b0;
    w_brk       = 1'b0;
    w_code      = bus.i_byte;
    if (bus.i_byte_en) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_byte == c_byte_f0) begin
            w_state_nxt = ST_BRK;
          end else if (bus.i_byte == c_byte_e0) begin
            w_state_nxt = ST_EXT;
          end else if (bus.i_byte == c_byte_e1) begin
            w_state_nxt = ST_PAUSE;
            w_cnt_nxt   = c_pause_len;
          end else if (!is_ignored(bus.i_byte)) begin
            w_emit = 1'b1;
          end
        end
        ST_EXT: begin
          if (bus.i_byte == c_byte_f0) begin
            w_state_nxt = ST_EXTBRK;
          end else if (bus.i_byte != c_byte_e0) begin
            w_emit      = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          w_emit      = 1'b1;
          w_brk       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        ST_EXTBRK: begin
          w_emit      = 1'b1;
          w_ext       = 1'b1;
          w_brk       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        ST_PAUSE: begin
          // Sequence bodies are swallowed; the last one yields one Pause make
          if (r_cnt == 3'd1) begin
            w_emit      = 1'b1;
            w_ext       = 1'b1;
            w_code      = PAUSE_CODE;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_push     = w_emit & (~w_brk | BREAK_EN);
  assign w_pop      = ~w_empty & bus.i_ready;
  assign w_event_in = {w_ext, w_brk, w_code};

  // Last make code and sticky drop flag
  always_ff @(posedge clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_scancode <= '0;
      r_overflow <= 1'b0;
    end else if (i_sclr) begin
      r_scancode <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_emit && !w_brk) r_scancode <= w_code;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  keyevent_decoder_sfifo #(
    .W     (c_evt_w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .i_arst_n (i_arst_n),
    .i_sclr   (i_sclr),
    .i_push   (w_push),
    .i_din    (w_event_in),
    .i_pop    (w_pop),
    .o_dout   (bus.o_event),
    .o_empty  (w_empty),
    .o_full   (w_full),
    .o_count  (w_count)
  );

  assign bus.o_valid    = ~w_empty;
  assign bus.o_count    = w_count;
  assign bus.o_scancode = r_scancode;
  assign bus.o_overflow = r_overflow;

endmodule
`default_nettype wire
